// File: rtl/parity_frame_rx_pkg.sv
// -----------------------------------------------------------------------------
// parity_frame_rx_pkg
// Shared definitions for the parity frame receiver:
//   rx_state_e  - 2-bit receiver state (IDLE, DATA, PARITY, STOP)
//   EVEN / ODD  - parity-mode constants used for the ODD_PARITY parameter
//   rx_cnt_width - width of the data-bit counter for a given word width
// -----------------------------------------------------------------------------
package parity_frame_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  localparam bit EVEN = 1'b0;
  localparam bit ODD  = 1'b1;

  // The counter must be able to hold DATA_W itself, hence the +1.
  function automatic int unsigned rx_cnt_width(input int unsigned data_w);
    return (data_w < 1) ? 1 : $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/parity_frame_rx_out_buf.sv
// -----------------------------------------------------------------------------
// rx_out_buf
// One-entry valid/ready holding register for completed frames.
//   clk, rst_n   - clock, asynchronous active-low reset
//   load_valid   - a new payload is offered this cycle
//   load_data    - payload offered with load_valid
//   out_data     - payload currently held
//   out_valid    - buffer holds an undelivered payload
//   out_ready    - consumer accepts when out_valid & out_ready
//   overrun      - one-cycle pulse: an offered payload was dropped (buffer full)
// A payload offered in the same cycle the held one drains replaces it, and
// out_valid stays high across that edge.
// -----------------------------------------------------------------------------
module rx_out_buf #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_valid,
  input  logic [W-1:0] load_data,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         overrun
);

  logic [W-1:0] data_q,    data_d;
  logic         valid_q,   valid_d;
  logic         overrun_q, overrun_d;
  logic         drain;
  logic         accept;

  always_comb begin
    // out_ready only matters while something is held.
    drain     = valid_q & out_ready;
    accept    = load_valid & (~valid_q | drain);
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (accept) begin
      data_d  = load_data;
      valid_d = 1'b1;
    end else if (drain) begin
      valid_d = 1'b0;
    end
    if (load_valid && !accept) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;

endmodule

// File: rtl/parity_frame_rx.sv
// -----------------------------------------------------------------------------
// parity_frame_rx
// Serial frame receiver with parity and framing check. A frame is a start bit
// (0), DATA_W data bits LSB first, a parity bit and a stop bit (1), each bit
// qualified by a one-cycle bit_valid strobe. The rebuilt word plus its error
// flags are handed to a one-entry valid/ready buffer.
//   clk, rst_n   - clock, asynchronous active-low reset
//   bit_valid    - qualifies bit_in; nothing advances while low
//   bit_in       - serial bit
//   out_data     - received word
//   out_par_err  - parity mismatch for out_data
//   out_frm_err  - stop bit was 0 for out_data
//   out_valid    - buffer holds an undelivered word
//   out_ready    - consumer handshake
//   overrun      - one-cycle pulse when a finished frame found the buffer full
//   busy         - receiver is inside a frame (not IDLE)
// Parameters: DATA_W (1..32), ODD_PARITY (0 = even, 1 = odd).
// -----------------------------------------------------------------------------
module parity_frame_rx
  import parity_frame_rx_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter bit          ODD_PARITY = EVEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_par_err,
  output logic              out_frm_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned     CNT_W    = rx_cnt_width(DATA_W);
  localparam int unsigned     PAY_W    = DATA_W + 2;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
  // Seeding the accumulator with the mode bit makes "nonzero" mean
  // "error" for both even and odd parity.
  localparam logic            PAR_INIT = ODD_PARITY ? ODD : EVEN;

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q,   par_d;
  logic              perr_q,  perr_d;

  logic              frame_done;
  logic [PAY_W-1:0]  frame_pay;
  logic [PAY_W-1:0]  buf_data;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    perr_d     = perr_q;
    frame_done = 1'b0;
    // Payload layout: {parity error, framing error, data word}.
    frame_pay  = {perr_q, ~bit_in, shreg_q};
    if (bit_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (!bit_in) begin
            state_d = ST_DATA;
            cnt_d   = '0;
            par_d   = PAR_INIT;
          end
        end
        ST_DATA: begin
          // Right shift with the new bit at the MSB: after DATA_W bits the
          // first bit received sits in bit 0.
          shreg_d             = shreg_q >> 1;
          shreg_d[DATA_W-1]   = bit_in;
          par_d               = par_q ^ bit_in;
          cnt_d               = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          par_d   = par_q ^ bit_in;
          perr_d  = par_q ^ bit_in;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          // A 0 stop bit is only a framing error; it never starts a frame.
          frame_done = 1'b1;
          state_d    = ST_IDLE;
          cnt_d      = '0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      perr_q  <= perr_d;
    end
  end

  rx_out_buf #(
    .W (PAY_W)
  ) u_out_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (frame_done),
    .load_data  (frame_pay),
    .out_data   (buf_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun)
  );

  assign out_data    = buf_data[DATA_W-1:0];
  assign out_frm_err = buf_data[DATA_W];
  assign out_par_err = buf_data[DATA_W+1];
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_parity_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_parity_frame_rx
// Drives the same serial stream into an even-parity and an odd-parity
// receiver (DATA_W=8) and compares both against a frame-level model: each
// frame is described as (word, parity bit, stop bit), and the model applies
// the buffer rules (load / drain / drop) once per clock.
// -----------------------------------------------------------------------------
module tb_parity_frame_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bit_valid;
  logic       bit_in;
  logic       out_ready;

  logic [7:0] od    [2];
  logic       ope   [2];
  logic       ofe   [2];
  logic       ov    [2];
  logic       oovr  [2];
  logic       obusy [2];

  // Reference model state, one entry per instance (0 = even, 1 = odd).
  logic [7:0] m_data  [2];
  logic       m_valid [2];
  logic       m_perr  [2];
  logic       m_ferr  [2];
  logic       m_ovr   [2];
  logic       m_busy;
  bit         rdy_rand;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  parity_frame_rx #(.DATA_W(8), .ODD_PARITY(1'b0)) dut_even (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
    .out_data(od[0]), .out_par_err(ope[0]), .out_frm_err(ofe[0]),
    .out_valid(ov[0]), .out_ready(out_ready), .overrun(oovr[0]), .busy(obusy[0])
  );

  parity_frame_rx #(.DATA_W(8), .ODD_PARITY(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
    .out_data(od[1]), .out_par_err(ope[1]), .out_frm_err(ofe[1]),
    .out_valid(ov[1]), .out_ready(out_ready), .overrun(oovr[1]), .busy(obusy[1])
  );

  task automatic chk(input string tag, input int inst,
                     input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, inst, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk("out_valid",   i, 32'(ov[i]),    32'(m_valid[i]));
      chk("out_data",    i, 32'(od[i]),    32'(m_data[i]));
      chk("out_par_err", i, 32'(ope[i]),   32'(m_perr[i]));
      chk("out_frm_err", i, 32'(ofe[i]),   32'(m_ferr[i]));
      chk("overrun",     i, 32'(oovr[i]),  32'(m_ovr[i]));
      chk("busy",        i, 32'(obusy[i]), 32'(m_busy));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_data[i]  = 8'h00;
      m_valid[i] = 1'b0;
      m_perr[i]  = 1'b0;
      m_ferr[i]  = 1'b0;
      m_ovr[i]   = 1'b0;
    end
    m_busy = 1'b0;
  endtask

  // One clock: apply inputs at the falling edge, advance the model at the
  // rising edge, compare shortly after it. 'done' marks the stop-bit strobe
  // of the frame (w, pbit, stopb); exp_busy is whether a frame is open
  // after this edge.
  task automatic step(input logic bv, input logic bi, input bit done,
                      input logic [7:0] w, input logic pbit, input logic stopb,
                      input logic exp_busy);
    @(negedge clk);
    bit_valid = bv;
    bit_in    = bi;
    if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      logic drain;
      logic x;
      drain    = m_valid[i] & out_ready;
      m_ovr[i] = 1'b0;
      if (done) begin
        if (!m_valid[i] || drain) begin
          x          = (^w) ^ pbit;
          m_data[i]  = w;
          m_perr[i]  = (x != (i == 1));
          m_ferr[i]  = ~stopb;
          m_valid[i] = 1'b1;
        end else begin
          m_ovr[i] = 1'b1;
        end
      end else if (drain) begin
        m_valid[i] = 1'b0;
      end
    end
    m_busy = exp_busy;
    #1;
    check_all();
  endtask

  task automatic gap(input int maxg, input logic b);
    repeat ($urandom_range(0, maxg)) step(1'b0, 1'($urandom & 1), 1'b0, 8'h00, 1'b0, 1'b1, b);
  endtask

  task automatic idle_strobe();
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  // stop_rdy >= 0 forces out_ready for the stop-bit cycle.
  task automatic send_frame(input logic [7:0] w, input logic pbit, input logic stopb,
                            input int maxg, input int stop_rdy);
    step(1'b1, 1'b0, 1'b0, w, pbit, stopb, 1'b1);
    for (int k = 0; k < 8; k++) begin
      gap(maxg, 1'b1);
      step(1'b1, w[k], 1'b0, w, pbit, stopb, 1'b1);
    end
    gap(maxg, 1'b1);
    step(1'b1, pbit, 1'b0, w, pbit, stopb, 1'b1);
    gap(maxg, 1'b1);
    if (stop_rdy >= 0) out_ready = stop_rdy[0];
    step(1'b1, stopb, 1'b1, w, pbit, stopb, 1'b0);
  endtask

  initial begin
    logic [7:0] w;
    logic       pbit;
    logic       stopb;

    rst_n     = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b1;
    out_ready = 1'b1;
    rdy_rand  = 1'b0;
    model_reset();

    // Reset state
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    idle_strobe();
    idle_strobe();

    // Clean even frame 0xA5
    send_frame(8'hA5, 1'b0, 1'b1, 0, -1);
    idle_strobe();

    // Parity bit 1 on 0xA5
    send_frame(8'hA5, 1'b1, 1'b1, 0, -1);
    idle_strobe();

    // 0x3C with gaps and a 0 stop bit, then a line-idle strobe
    send_frame(8'h3C, 1'b0, 1'b0, 3, -1);
    idle_strobe();

    // Backpressure: second frame dropped with an overrun pulse
    out_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 1, -1);
    send_frame(8'h22, 1'b0, 1'b1, 1, -1);
    idle_strobe();
    out_ready = 1'b1;
    idle_strobe();
    idle_strobe();

    // Drain and reload on the same edge
    out_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 0, -1);
    send_frame(8'h22, 1'b0, 1'b1, 0, 1);
    out_ready = 1'b1;
    idle_strobe();

    // Reset mid-frame with a word still held in the buffer
    out_ready = 1'b0;
    send_frame(8'h77, 1'b0, 1'b1, 0, -1);
    step(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b1, 2, -1);
    idle_strobe();

    // Randomized frames, gaps and consumer backpressure
    rdy_rand = 1'b1;
    repeat (40) begin
      w     = 8'($urandom);
      pbit  = ($urandom_range(0, 3) == 0) ? ~(^w) : (^w);
      stopb = ($urandom_range(0, 4) != 0);
      send_frame(w, pbit, stopb, 3, -1);
      if ($urandom_range(0, 1) == 1) idle_strobe();
    end
    rdy_rand  = 1'b0;
    out_ready = 1'b1;
    idle_strobe();
    idle_strobe();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
